// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor (a - b - bin), LSB first, with a start/done handshake.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t           r_state, w_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_p, r_diff;
  logic [CW-1:0]    r_cnt;
  logic             r_br, r_bout;
  logic             w_accept, w_run, w_last, w_d, w_br;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  always_comb begin
    w_accept = start && (r_state != S_RUN);
    w_run    = (r_state == S_RUN);
    w_last   = w_run && (r_cnt == CW'(WIDTH-1));
    w_nxt    = w_accept ? S_RUN : w_last ? S_DONE : (r_state == S_DONE) ? S_IDLE : r_state;
  end
  // single full-subtractor cell; bit 0 of the operand shift regs is the current bit
  assign w_d  = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br = (~r_a[0] & r_b[0]) | (~r_a[0] & r_br) | (r_b[0] & r_br);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_p    <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_br  <= bin;
      r_cnt <= '0;
    end else if (w_run) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_br  <= w_br;
      r_p   <= {w_d, r_p[WIDTH-1:1]};
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_diff <= {w_d, r_p[WIDTH-1:1]};
        r_bout <= w_br;
      end
    end
`ifdef SERIAL_SUB_OVF_EN
  // operand MSBs are kept aside because the operand regs are shifted away
  logic r_am, r_bm, r_ovf;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_am  <= 1'b0;
      r_bm  <= 1'b0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_am <= a[WIDTH-1];
      r_bm <= b[WIDTH-1];
    end else if (w_last) begin
      r_ovf <= (r_am != r_bm) && (w_d != r_am);
    end
  assign ovf = r_ovf;
`endif
  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign diff = r_diff;
  assign bout = r_bout;
endmodule
